// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter
//   between N_REQ rectangle drawers. Requesters are granted round-robin. The
//   granted filled rectangle is scanned one pixel per clock, row by row, onto
//   vga_x/vga_y/vga_colour/vga_plot. A one-cycle one-hot ack follows the last pixel.
//
// Optional build macro:
//   VGA_ARB_CLIP_EN - pixel coordinates are computed unwrapped, and vga_plot is
//                     suppressed for any pixel outside 160x120. The draw timing
//                     is unchanged. When the macro is undefined, coordinates wrap
//                     modulo 256/128 and every drawn pixel is plotted.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   req[N_REQ]           level request per drawer, held until its ack
//   req_x/y/w/h/colour   packed per-requester rectangle fields, slice i per drawer
//   ack[N_REQ]           one-cycle one-hot completion pulse
//   busy                 high while drawing and during the ack cycle
//   vga_x/y/colour/plot  adapter pixel write port (registered)
module vga_draw_arbiter #(
  parameter int N_REQ  = 4,
  parameter int SIZE_W = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*8-1:0]      req_x,
  input  logic [N_REQ*7-1:0]      req_y,
  input  logic [N_REQ*SIZE_W-1:0] req_w,
  input  logic [N_REQ*SIZE_W-1:0] req_h,
  input  logic [N_REQ*3-1:0]      req_colour,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0]  ACK_ONE = 1;
  localparam logic [SIZE_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  cur_idx;
  logic [7:0]        base_x;
  logic [6:0]        base_y;
  logic [SIZE_W-1:0] base_w;
  logic [SIZE_W-1:0] base_h;
  logic [SIZE_W-1:0] col;
  logic [SIZE_W-1:0] row;

  // Round-robin winner: first asserted request after last_grant, wrapping.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((32'(last_grant) + k) % N_REQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  logic [7:0]        win_x;
  logic [6:0]        win_y;
  logic [SIZE_W-1:0] win_w;
  logic [SIZE_W-1:0] win_h;
  logic [2:0]        win_colour;

  assign win_x      = req_x[win_idx*8 +: 8];
  assign win_y      = req_y[win_idx*7 +: 7];
  assign win_w      = req_w[win_idx*SIZE_W +: SIZE_W];
  assign win_h      = req_h[win_idx*SIZE_W +: SIZE_W];
  assign win_colour = req_colour[win_idx*3 +: 3];

  // col/row name the pixel currently on the outputs; the registered outputs
  // are loaded with the *next* pixel so the first plot lands one cycle after grant.
  logic              last_col;
  logic              last_pix;
  logic [SIZE_W-1:0] nxt_col;
  logic [SIZE_W-1:0] nxt_row;

  assign last_col = (col == base_w - CNT_ONE);
  assign last_pix = last_col && (row == base_h - CNT_ONE);
  assign nxt_col  = last_col ? '0 : col + CNT_ONE;
  assign nxt_row  = last_col ? row + CNT_ONE : row;

  // One adder pair serves both the grant pixel (offset 0) and the scan.
  logic [7:0]        src_x;
  logic [6:0]        src_y;
  logic [SIZE_W-1:0] off_c;
  logic [SIZE_W-1:0] off_r;

  always_comb begin
    if (state == IDLE) begin
      src_x = win_x;
      src_y = win_y;
      off_c = '0;
      off_r = '0;
    end else begin
      src_x = base_x;
      src_y = base_y;
      off_c = nxt_col;
      off_r = nxt_row;
    end
  end

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       pix_on;

`ifdef VGA_ARB_CLIP_EN
  logic [8:0] ux;
  logic [7:0] uy;

  always_comb begin
    ux     = {1'b0, src_x} + 9'(off_c);
    uy     = {1'b0, src_y} + 8'(off_r);
    pix_x  = ux[7:0];
    pix_y  = uy[6:0];
    pix_on = (ux < 9'd160) && (uy < 8'd120);
  end
`else
  always_comb begin
    pix_x  = src_x + 8'(off_c);
    pix_y  = src_y + 7'(off_r);
    pix_on = 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      cur_idx    <= '0;
      base_x     <= '0;
      base_y     <= '0;
      base_w     <= '0;
      base_h     <= '0;
      col        <= '0;
      row        <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            last_grant <= win_idx;
            cur_idx    <= win_idx;
            base_x     <= win_x;
            base_y     <= win_y;
            base_w     <= win_w;
            base_h     <= win_h;
            col        <= '0;
            row        <= '0;
            busy       <= 1'b1;
            if (win_w != '0 && win_h != '0) begin
              state      <= DRAW;
              vga_x      <= pix_x;
              vga_y      <= pix_y;
              vga_colour <= win_colour;
              vga_plot   <= pix_on;
            end else begin
              state <= DONE;
              ack   <= ACK_ONE << win_idx;
            end
          end
        end
        DRAW: begin
          if (last_pix) begin
            state    <= DONE;
            vga_plot <= 1'b0;
            ack      <= ACK_ONE << cur_idx;
          end else begin
            col      <= nxt_col;
            row      <= nxt_row;
            vga_x    <= pix_x;
            vga_y    <= pix_y;
            vga_plot <= pix_on;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
module tb_vga_draw_arbiter;
  localparam int N  = 4;
  localparam int SW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_x;
  logic [N*7-1:0]  req_y;
  logic [N*SW-1:0] req_w;
  logic [N*SW-1:0] req_h;
  logic [N*3-1:0]  req_colour;
  logic [N-1:0]    ack;
  logic            busy;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;

  vga_draw_arbiter #(.N_REQ(N), .SIZE_W(SW)) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour), .ack(ack), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { int idx; int cyc; } ack_t;

  pix_t pix_q[$];
  ack_t ack_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, ack_count = 0, plot_cnt = 0, busy_cnt = 0;
  int mdl_last = N - 1;
  bit mon_en = 0;
  int fx[N], fy[N], fw[N], fh[N], fc[N];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void set_fields(input int i, input int x, input int y,
                                     input int w, input int h, input int c);
    fx[i] = x; fy[i] = y; fw[i] = w; fh[i] = h; fc[i] = c;
    req_x[i*8 +: 8]      = 8'(x);
    req_y[i*7 +: 7]      = 7'(y);
    req_w[i*SW +: SW]    = SW'(w);
    req_h[i*SW +: SW]    = SW'(h);
    req_colour[i*3 +: 3] = 3'(c);
  endfunction

  // Reference: raster order, row-major, coordinates wrap (or clip) as the adapter sees them.
  function automatic int push_rect(input int i);
    int n = 0;
    for (int r = 0; r < fh[i]; r++)
      for (int c = 0; c < fw[i]; c++) begin
        int ux = fx[i] + c;
        int uy = fy[i] + r;
`ifdef VGA_ARB_CLIP_EN
        if (ux < 160 && uy < 120)
`endif
        begin
          pix_q.push_back('{ux % 256, uy % 128, fc[i]});
          n++;
        end
      end
    return n;
  endfunction

  // Scoreboard monitor: compares every plotted pixel and every ack.
  always @(negedge clock) begin
    pix_t p;
    ack_t a;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (vga_plot) begin
        plot_cnt++;
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: unexpected plot at (%0d,%0d) cycle %0d", vga_x, vga_y, cyc);
        end else begin
          p = pix_q.pop_front();
          if (int'(vga_x) != p.x || int'(vga_y) != p.y || int'(vga_colour) != p.c) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d) cycle %0d",
                     vga_x, vga_y, vga_colour, p.x, p.y, p.c, cyc);
          end
        end
      end
      if (ack != '0) begin
        ack_count++;
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack: unexpected ack=%b cycle %0d", ack, cyc);
        end else begin
          a = ack_q.pop_front();
          if (int'(ack) != (1 << a.idx) || cyc != a.cyc) begin
            errors++;
            $display("FAIL ack: got ack=%b at cycle %0d expected idx %0d at cycle %0d",
                     ack, cyc, a.idx, a.cyc);
          end
        end
      end
    end
  end

  // Issue requests in mask during one IDLE cycle; predict grant order round-robin.
  // held=1: all of mask stays asserted for n_grants grants, then drops together.
  task automatic serve(input logic [N-1:0] mask, input int n_grants, input bit held,
                       input int budget);
    int order[$];
    logic [N-1:0] rem, dm;
    int lg, t, c0, target, p0, b0, exp_plots, exp_busy;
    @(posedge clock); #1;
    c0 = cyc;
    lg = mdl_last;
    rem = mask;
    while (held ? (order.size() < n_grants) : (rem != '0)) begin
      for (int k = 1; k <= N; k++) begin
        int c = (lg + k) % N;
        if (held ? mask[c] : rem[c]) begin
          order.push_back(c);
          rem[c] = 1'b0;
          lg = c;
          break;
        end
      end
    end
    t = c0;
    exp_plots = 0;
    exp_busy = 0;
    foreach (order[j]) begin
      int i = order[j];
      exp_plots += push_rect(i);
      exp_busy += fw[i] * fh[i] + 1;
      ack_q.push_back('{i, t + fw[i] * fh[i] + 1});
      t = t + fw[i] * fh[i] + 2;
      mdl_last = i;
    end
    p0 = plot_cnt;
    b0 = busy_cnt;
    target = ack_count + order.size();
    req = req | mask;
    for (int n = 0; n < budget && ack_count < target; n++) begin
      @(negedge clock); #1;
      if (ack != '0) begin
        dm = held ? ((ack_count >= target) ? mask : '0) : ack;
        @(posedge clock); #1;
        req = req & ~dm;
      end
    end
    if (ack_count < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d acks expected %0d", ack_count - (target - order.size()),
               order.size());
      req = '0;
    end
    check_eq("plot_count", plot_cnt - p0, exp_plots);
    check_eq("busy_count", busy_cnt - b0, exp_busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0;
    reset = 1'b1;
    req = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    for (int i = 0; i < N; i++) set_fields(i, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1;
    @(negedge clock);
    check_eq("reset_outputs", int'({vga_x, vga_y, vga_colour, vga_plot, ack, busy}), 0);

    set_fields(0, 10, 20, 2, 3, 4);
    serve(4'b0001, 1, 0, 100);
    set_fields(2, 7, 9, 0, 5, 1);
    serve(4'b0100, 1, 0, 100);
    set_fields(3, 158, 0, 4, 1, 6);
    serve(4'b1000, 1, 0, 100);
    for (int i = 0; i < N; i++) set_fields(i, 20 + 5 * i, 30 + i, 1, 1, i + 1);
    serve(4'b1111, 5, 1, 200);
    set_fields(3, 0, 0, 31, 31, 5);
    serve(4'b1000, 1, 0, 2000);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        set_fields(i, $urandom_range(0, 255), $urandom_range(0, 127),
                   $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 7));
      serve(N'($urandom_range(1, 15)), 0, 0, 400);
    end

    // Reset during the third plot cycle of a 4x4 draw by requester 0.
    set_fields(0, 40, 50, 4, 4, 7);
    @(posedge clock); #1;
    c0 = cyc;
    p0 = plot_cnt;
    for (int c = 0; c < 3; c++) pix_q.push_back('{40 + c, 50, 7});
    req = 4'b0001;
    while (cyc < c0 + 3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    req = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_last = N - 1;
    @(negedge clock); #1;
    check_eq("reset_mid_outputs", int'({vga_x, vga_y, vga_colour, vga_plot, ack, busy}), 0);
    check_eq("reset_mid_plots", plot_cnt - p0, 3);
    repeat (5) @(negedge clock);
    check_eq("reset_mid_pix_left", pix_q.size(), 0);

    set_fields(0, 1, 2, 1, 1, 2);
    set_fields(1, 3, 4, 1, 1, 3);
    serve(4'b0011, 0, 0, 100);
    set_fields(1, 100, 60, 3, 2, 5);
    serve(4'b0010, 0, 0, 100);

    repeat (3) @(negedge clock);
    check_eq("pix_leftover", pix_q.size(), 0);
    check_eq("ack_leftover", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
